// File: rtl/varint_deser_if.sv
// rtl/varint_deser_if.sv - byte-in / decoded-result-out handshake bundle for varint_deser
interface varint_deser_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_value;
    logic [3:0]  out_len;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;

    // slave: the decoder; master: whoever feeds bytes and drains results
    modport slave (
        input  in_byte,
        input  in_valid,
        output in_ready,
        output out_value,
        output out_len,
        output out_err,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_byte,
        output in_valid,
        input  in_ready,
        input  out_value,
        input  out_len,
        input  out_err,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/varint_deser.sv
// rtl/varint_deser.sv - LEB128-style varint byte-stream decoder with held result handshake
module varint_deser #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    varint_deser_if.slave    bus,
    output logic [CNT_W-1:0] dec_count
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [3:0]       idx;
    logic [3:0]       idx_n;
    logic [63:0]      acc;
    logic [63:0]      acc_n;
    logic [3:0]       len_r;
    logic [3:0]       len_n;
    logic             err_r;
    logic             err_n;
    logic [CNT_W-1:0] cnt_n;

    logic             byte_xfer;
    logic             res_xfer;
    logic             last_idx;
    logic             ovf;
    logic [6:0]       shamt;
    logic [63:0]      group;

    // Byte 9 only has room for one payload bit (bit 63); anything more is overflow
    always_comb begin
        byte_xfer = (state == ACCUM) && bus.in_valid;
        res_xfer  = (state == HOLD) && bus.out_ready;
        last_idx  = (idx == 4'd9);
        ovf       = last_idx && (bus.in_byte[7] || (bus.in_byte[6:1] != 6'd0));
        shamt     = 7'(idx) * 7'd7;
        if (last_idx) begin
            group = {bus.in_byte[0], 63'd0};
        end else begin
            group = {57'd0, bus.in_byte[6:0]} << shamt;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        acc_n   = acc;
        len_n   = len_r;
        err_n   = err_r;
        cnt_n   = dec_count;
        case (state)
            ACCUM: begin
                if (byte_xfer) begin
                    acc_n = acc | group;
                    if (ovf) begin
                        state_n = HOLD;
                        len_n   = 4'd10;
                        err_n   = 1'b1;
                    end else if (!bus.in_byte[7]) begin
                        state_n = HOLD;
                        len_n   = idx + 4'd1;
                        err_n   = 1'b0;
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (res_xfer) begin
                    state_n = ACCUM;
                    idx_n   = 4'd0;
                    acc_n   = 64'd0;
                    len_n   = 4'd0;
                    err_n   = 1'b0;
                    cnt_n   = dec_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            idx       <= 4'd0;
            acc       <= 64'd0;
            len_r     <= 4'd0;
            err_r     <= 1'b0;
            dec_count <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            acc       <= acc_n;
            len_r     <= len_n;
            err_r     <= err_n;
            dec_count <= cnt_n;
        end
    end

    // No bypass: in_ready depends only on state, so a byte cannot enter while a result leaves
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_value = acc;
    assign bus.out_len   = len_r;
    assign bus.out_err   = err_r;

endmodule

// File: tb/tb_varint_deser.sv
// tb/tb_varint_deser.sv - table-driven and scoreboard bench for varint_deser
module tb_varint_deser;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dec_count;

    varint_deser_if ifc ();

    varint_deser #(.CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifc.slave),
        .dec_count (dec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [79:0] bytes;
        int          n;
        logic [63:0] v;
        logic [3:0]  len;
        logic        err;
    } vec_t;

    typedef struct {
        logic [63:0] v;
        logic [3:0]  len;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t tbl[13];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_xfer_cyc = 0;
    int   prev_xfer_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Result monitor: sampled at negedge, a handshake seen here completes on the next posedge
    always @(negedge clk) begin
        if (!rst && ifc.out_valid && ifc.out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got value 0x%0h required none", ifc.out_value);
            end else begin
                mon_e = sbq.pop_front();
                check("out_value", ifc.out_value, mon_e.v);
                check("out_len", 64'(ifc.out_len), 64'(mon_e.len));
                check("out_err", 64'(ifc.out_err), 64'(mon_e.err));
            end
            prev_xfer_cyc = last_xfer_cyc;
            last_xfer_cyc = cyc;
        end
    end

    function automatic vec_t mk(input logic [79:0] b, input int n, input logic [63:0] v,
                                input logic [3:0] len, input logic err);
        vec_t t;
        t.bytes = b;
        t.n     = n;
        t.v     = v;
        t.len   = len;
        t.err   = err;
        return t;
    endfunction

    function automatic vec_t encode(input logic [63:0] v);
        vec_t        t;
        logic [63:0] r;
        r       = v;
        t.bytes = '0;
        t.n     = 0;
        for (int i = 0; i < 10; i++) begin
            if (t.n == i) begin
                t.bytes[8*i +: 8] = {(r >> 7) != 64'd0, r[6:0]};
                r   = r >> 7;
                t.n = i + 1;
                if (r == 64'd0) break;
            end
        end
        t.v   = v;
        t.len = 4'(t.n);
        t.err = 1'b0;
        return t;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        ifc.in_byte  = b;
        ifc.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 required 1");
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic send_vec(input vec_t t);
        exp_t e;
        e.v   = t.v;
        e.len = t.len;
        e.err = t.err;
        sbq.push_back(e);
        for (int i = 0; i < t.n; i++) send_byte(t.bytes[8*i +: 8]);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending required 0", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(80'h01, 1, 64'd1, 4'd1, 1'b0);
        tbl[1]  = mk(80'h02AC, 2, 64'd300, 4'd2, 1'b0);
        tbl[2]  = mk(80'h01FFFFFFFFFFFFFFFFFF, 10, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b0);
        tbl[3]  = mk(80'h82808080808080808080, 10, 64'd0, 4'd10, 1'b1);
        tbl[4]  = mk(80'h05, 1, 64'd5, 4'd1, 1'b0);
        tbl[5]  = mk(80'h0080, 2, 64'd0, 4'd2, 1'b0);
        tbl[6]  = mk(80'h7F, 1, 64'd127, 4'd1, 1'b0);
        tbl[7]  = mk(80'h0196, 2, 64'd150, 4'd2, 1'b0);
        tbl[8]  = mk(80'h268EE5, 3, 64'd624485, 4'd3, 1'b0);
        tbl[9]  = mk(80'h81FFFFFFFFFFFFFFFFFF, 10, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b1);
        tbl[10] = mk(80'h01808080808080808080, 10, 64'h8000_0000_0000_0000, 4'd10, 1'b0);
        tbl[11] = mk(80'h02FFFFFFFFFFFFFFFFFF, 10, 64'h7FFF_FFFF_FFFF_FFFF, 4'd10, 1'b1);
        tbl[12] = mk(80'h00, 1, 64'd0, 4'd1, 1'b0);

        ifc.in_byte   = 8'd0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("rst_out_value", ifc.out_value, 64'd0);
        check("rst_out_len", 64'(ifc.out_len), 64'd0);
        check("rst_out_err", 64'(ifc.out_err), 64'd0);
        check("rst_dec_count", 64'(dec_count), 64'd0);
        check("rst_in_ready", 64'(ifc.in_ready), 64'd1);

        // Single-byte latency: result must be valid in the cycle right after the transfer
        @(posedge clk);
        #1;
        sbq.push_back('{64'd1, 4'd1, 1'b0});
        send_byte(8'h01);
        @(negedge clk);
        check("latency_out_valid", 64'(ifc.out_valid), 64'd1);
        check("latency_in_ready", 64'(ifc.in_ready), 64'd0);
        wait_drain();
        check("dec_count_first", 64'(dec_count), 64'd1);

        for (int i = 0; i < 13; i++) send_vec(tbl[i]);
        wait_drain();
        check("dec_count_table", 64'(dec_count), 64'd14);

        // Back-to-back 2-byte varints with out_ready high: one result every 3 cycles
        send_vec(tbl[1]);
        send_vec(tbl[7]);
        wait_drain();
        check("throughput_gap", 64'(last_xfer_cyc - prev_xfer_cyc), 64'd3);

        // Result held against backpressure for 5 cycles, accepted on the 6th
        ifc.out_ready = 1'b0;
        send_vec(tbl[7]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", 64'(ifc.out_valid), 64'd1);
            check("hold_out_value", ifc.out_value, 64'd150);
            check("hold_in_ready", 64'(ifc.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b1;
        wait_drain();
        check("post_hold_in_ready", 64'(ifc.in_ready), 64'd1);
        check("post_hold_out_valid", 64'(ifc.out_valid), 64'd0);
        check("dec_count_hold", 64'(dec_count), 64'd17);

        // Reset mid-varint discards the partial value
        send_byte(8'hFF);
        send_byte(8'hFF);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("midrst_dec_count", 64'(dec_count), 64'd0);
        check("midrst_in_ready", 64'(ifc.in_ready), 64'd1);
        @(posedge clk);
        #1;
        sbq.push_back('{64'd7, 4'd1, 1'b0});
        send_byte(8'h07);
        wait_drain();
        check("midrst_dec_count_after", 64'(dec_count), 64'd1);

        // Round trip of random values of varied magnitude
        send_vec(encode(64'd0));
        send_vec(encode(64'hFFFF_FFFF_FFFF_FFFF));
        for (int i = 0; i < 20; i++) begin
            send_vec(encode({$urandom, $urandom} >> $urandom_range(0, 63)));
        end
        wait_drain();
        check("dec_count_roundtrip", 64'(dec_count), 64'd23);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/varint_deser.md
VARINT_DESER -- requirements
Module: varint_deser

Interface
REQ-001 Parameter: CNT_W, 32, width of the decoded-varint counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_byte  input  8  varint byte: bit 7 = continuation, bits 6:0 = payload.
REQ-005 in_valid  input  1  in_byte valid this cycle.
REQ-006 in_ready  output  1  block accepts in_byte this cycle.
REQ-007 out_value  output  64  decoded value, LSB-group first.
REQ-008 out_len  output  4  number of bytes consumed, 1..10.
REQ-009 out_err  output  1  overflow/malformed flag for this result.
REQ-010 out_valid  output  1  result valid; held until accepted.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 dec_count  output  CNT_W  results handed off since reset (errors included).

Function
REQ-013 Byte transfer: occurs when in_valid && in_ready in the same cycle; no other cycle consumes a byte.
REQ-014 Result transfer: occurs when out_valid && out_ready in the same cycle.
REQ-015 States: ACCUM (collecting bytes) and HOLD (result pending); the reset state is ACCUM.
REQ-016 in_ready = 1 in ACCUM and 0 in HOLD. No bypass: a byte is never accepted in the cycle a result is accepted.
REQ-017 Byte index idx: 4 bits, 0..9, cleared on entry to ACCUM. Each transfer places payload bits 6:0 at out_value[7*idx+6 : 7*idx] for idx 0..8.
REQ-018 At idx 9, only in_byte[0] is placed, into out_value[63]; bits 6:1 are not stored.
REQ-019 Accumulator: cleared to 0 at the start of each varint; bits above the terminating group remain 0.
REQ-020 Termination (in_byte[7]=0, no error): ACCUM -> HOLD; out_len = idx+1; out_err = 0.
REQ-021 Continuation (in_byte[7]=1 and idx<9): idx increments; the block stays in ACCUM.
REQ-022 Overflow, any of:
  - idx = 9 with in_byte[7] = 1;
  - idx = 9 with in_byte[6:1] != 0.
  Action: ACCUM -> HOLD; out_err = 1; out_len = 10; out_value holds the bits accumulated so far, including bit 63 from in_byte[0].
REQ-023 Latency: out_valid rises in the cycle after the terminating/erroring byte transfer, so a 1-byte varint yields a result 1 cycle after the transfer.
REQ-024 HOLD: out_value, out_len and out_err are stable; out_valid = 1 until the result transfer.
REQ-025 On result transfer: HOLD -> ACCUM; out_valid = 0 next cycle; idx and accumulator cleared; dec_count increments, wrapping from 2^CNT_W-1 to 0.
REQ-026 Throughput: with out_ready tied high, one varint of n bytes completes every n+1 cycles.
REQ-027 Non-minimal encodings (e.g. 0x80 0x00): decoded normally, value 0, out_len 2, out_err 0.
REQ-028 in_valid low in ACCUM: state, idx and accumulator unchanged.
REQ-029 Round trip: for any 64-bit value v, the 10-byte-max encoding of v (LSB group first, continuation on all but the last byte) decodes to v with out_err = 0.

Reset
REQ-030 While rst = 1 at a clock edge, the next state is ACCUM, with:
  - idx = 0 and accumulator = 0;
  - out_valid = 0, out_value = 0, out_len = 0, out_err = 0, dec_count = 0;
  - in_ready = 1 from the first cycle after rst deasserts.
REQ-031 Reset mid-varint or in HOLD discards partial or pending results; no result is emitted for the discarded data.
REQ-032 Reset has priority over all simultaneous transfers.

Verification
REQ-033 in_byte 0x01, out_ready=1 -> next cycle out_value=1, out_len=1, out_err=0, out_valid=1; dec_count=1 after transfer.
REQ-034 bytes 0xAC,0x02 -> out_value=300 (0x12C), out_len=2, out_err=0.
REQ-035 bytes 0xFF x9 then 0x01 -> out_value=0xFFFF_FFFF_FFFF_FFFF, out_len=10, out_err=0.
REQ-036 bytes 0x80 x9 then 0x82 -> out_err=1, out_len=10; the next byte 0x05 decodes to 5 with out_err=0.
REQ-037 result 0x96,0x01 (150) with out_ready=0 for 5 cycles -> out_valid and out_value=150 stable, in_ready=0 throughout; transfer on the 6th cycle, then ACCUM.
REQ-038 bytes 0xFF,0xFF, then rst for 1 cycle, then 0x07 -> out_value=7, out_len=1; no result is emitted for the pre-reset bytes; dec_count=1.
